// File: rtl/quant_requant_pipe_if.sv
// quant_requant_pipe_if: beat stream, coefficient config and status bundle
// master drives beats/config, slave is the requantizer
interface quant_requant_pipe_if #(
  parameter int LANES   = 4,
  parameter int ACC_W   = 32,
  parameter int MULT_W  = 16,
  parameter int SHIFT_W = 5,
  parameter int OUT_W   = 8,
  parameter int CH_AW   = 6
);
  logic                   in_valid;
  logic [CH_AW-1:0]       in_ch;
  logic [LANES*ACC_W-1:0] data_in;
  logic                   cfg_we;
  logic [CH_AW-1:0]       cfg_addr;
  logic [MULT_W-1:0]      cfg_mult;
  logic [SHIFT_W-1:0]     cfg_shift;
  logic [OUT_W-1:0]       cfg_zp;
  logic                   sat_clr;
  logic                   out_valid;
  logic [LANES*OUT_W-1:0] data_out;
  logic [15:0]            sat_cnt;

  modport master (
    output in_valid, in_ch, data_in,
    output cfg_we, cfg_addr, cfg_mult,
    output cfg_shift, cfg_zp, sat_clr,
    input  out_valid, data_out, sat_cnt
  );

  modport slave (
    input  in_valid, in_ch, data_in,
    input  cfg_we, cfg_addr, cfg_mult,
    input  cfg_shift, cfg_zp, sat_clr,
    output out_valid, data_out, sat_cnt
  );
endinterface

// File: rtl/quant_requant_pipe.sv
// quant_requant_pipe: 4-stage per-channel requantizer
// acc * mult >> (FRAC_W+shift), round half up, + zp, clamp
module quant_requant_pipe #(
  parameter int LANES      = 4,
  parameter int ACC_W      = 32,
  parameter int MULT_W     = 16,
  parameter int FRAC_W     = 15,
  parameter int SHIFT_W    = 5,
  parameter int OUT_W      = 8,
  parameter bit OUT_SIGNED = 1'b0,
  parameter int CH_NUM     = 64,
  parameter int CH_AW      = $clog2(CH_NUM)
) (
  input logic sclk,
  input logic s_rst_n,
  quant_requant_pipe_if.slave bus
);
  localparam int PW  = ACC_W + MULT_W + 1;
  localparam int SW  = PW + 1;
  localparam int VW  = SW + 1;
  localparam int SHW = $clog2(FRAC_W + (1 << SHIFT_W)) + 1;
  localparam int NW  = $clog2(LANES + 1);

  localparam logic signed [VW-1:0] V_HI =
    OUT_SIGNED ? VW'((1 << (OUT_W - 1)) - 1)
               : VW'((1 << OUT_W) - 1);
  localparam logic signed [VW-1:0] V_LO =
    OUT_SIGNED ? -VW'(1 << (OUT_W - 1))
               : '0;

  typedef struct packed {
    logic [MULT_W-1:0]  mult;
    logic [SHIFT_W-1:0] shift;
    logic [OUT_W-1:0]   zp;
  } coef_t;

  coef_t tbl [CH_NUM];
  logic  ch_ok;
  logic  wr_ok;

  if ((1 << CH_AW) > CH_NUM) begin : g_rng
    assign ch_ok = bus.in_ch < CH_AW'(CH_NUM);
    assign wr_ok = bus.cfg_addr < CH_AW'(CH_NUM);
  end else begin : g_full
    assign ch_ok = 1'b1;
    assign wr_ok = 1'b1;
  end

  // table is deliberately not reset; it survives s_rst_n
  always_ff @(posedge sclk)
    if (bus.cfg_we && wr_ok)
      tbl[bus.cfg_addr] <= coef_t'({bus.cfg_mult,
                                    bus.cfg_shift,
                                    bus.cfg_zp});

  // S0: capture beat, read coefficients (old value on same-cycle write)
  logic                    s0_v;
  coef_t                   s0_c;
  logic signed [ACC_W-1:0] s0_acc [LANES];

  always_ff @(posedge sclk or negedge s_rst_n)
    if (!s_rst_n) begin
      s0_v <= 1'b0;
      s0_c <= '0;
      for (int i = 0; i < LANES; i++)
        s0_acc[i] <= '0;
    end else begin
      s0_v <= bus.in_valid;
      s0_c <= ch_ok ? tbl[bus.in_ch] : '0;
      for (int i = 0; i < LANES; i++)
        s0_acc[i] <= bus.data_in[i*ACC_W +: ACC_W];
    end

  // S1: product
  logic                 s1_v;
  logic [SHW-1:0]       s1_s;
  logic [OUT_W-1:0]     s1_zp;
  logic signed [PW-1:0] s1_p [LANES];

  always_ff @(posedge sclk or negedge s_rst_n)
    if (!s_rst_n) begin
      s1_v  <= 1'b0;
      s1_s  <= '0;
      s1_zp <= '0;
      for (int i = 0; i < LANES; i++)
        s1_p[i] <= '0;
    end else begin
      s1_v  <= s0_v;
      s1_s  <= SHW'(FRAC_W) + SHW'(s0_c.shift);
      s1_zp <= s0_c.zp;
      for (int i = 0; i < LANES; i++)
        s1_p[i] <= PW'(s0_acc[i])
                 * PW'($signed({1'b0, s0_c.mult}));
    end

  // S2: rounding shift, one extra bit so the add cannot wrap
  logic signed [SW-1:0] rnd;
  logic signed [SW-1:0] sum [LANES];

  always_comb begin
    rnd = SW'(1) << (s1_s - SHW'(1));
    for (int i = 0; i < LANES; i++)
      sum[i] = SW'(s1_p[i]) + rnd;
  end

  logic                 s2_v;
  logic [OUT_W-1:0]     s2_zp;
  logic signed [SW-1:0] s2_r [LANES];

  always_ff @(posedge sclk or negedge s_rst_n)
    if (!s_rst_n) begin
      s2_v  <= 1'b0;
      s2_zp <= '0;
      for (int i = 0; i < LANES; i++)
        s2_r[i] <= '0;
    end else begin
      s2_v  <= s1_v;
      s2_zp <= s1_zp;
      for (int i = 0; i < LANES; i++)
        s2_r[i] <= sum[i] >>> s1_s;
    end

  // S3: zero point, clamp, saturation count
  logic signed [VW-1:0]   zpx;
  logic signed [VW-1:0]   v [LANES];
  logic [LANES*OUT_W-1:0] res;
  logic [NW-1:0]          nsat;
  logic [16:0]            sat_sum;

  always_comb begin
    if (OUT_SIGNED) zpx = VW'($signed(s2_zp));
    else            zpx = VW'(s2_zp);
    res  = '0;
    nsat = '0;
    for (int i = 0; i < LANES; i++) begin
      v[i] = VW'(s2_r[i]) + zpx;
      if (v[i] > V_HI) begin
        res[i*OUT_W +: OUT_W] = V_HI[OUT_W-1:0];
        nsat = nsat + NW'(1);
      end else if (v[i] < V_LO) begin
        res[i*OUT_W +: OUT_W] = V_LO[OUT_W-1:0];
        nsat = nsat + NW'(1);
      end else begin
        res[i*OUT_W +: OUT_W] = v[i][OUT_W-1:0];
      end
    end
  end

  assign sat_sum = {1'b0, bus.sat_cnt} + 17'(nsat);

  always_ff @(posedge sclk or negedge s_rst_n)
    if (!s_rst_n) begin
      bus.out_valid <= 1'b0;
      bus.data_out  <= '0;
      bus.sat_cnt   <= '0;
    end else begin
      bus.out_valid <= s2_v;
      if (s2_v)
        bus.data_out <= res;
      if (bus.sat_clr)
        bus.sat_cnt <= '0;
      else if (s2_v)
        bus.sat_cnt <= sat_sum[16] ? 16'hFFFF
                                   : sat_sum[15:0];
    end
endmodule

// File: tb/tb_quant_requant_pipe.sv
// tb_quant_requant_pipe: directed + random beats vs arithmetic model
// dut 0: unsigned, 48 channels; dut 1: signed, 64 channels
module tb_quant_requant_pipe;
  localparam int LANES = 4;
  localparam int CH_AW = 6;
  localparam int CHN0  = 48;
  localparam int CHN1  = 64;

  logic sclk = 1'b0;
  logic s_rst_n = 1'b1;
  always #5 sclk = ~sclk;

  quant_requant_pipe_if #(.LANES(LANES), .CH_AW(CH_AW)) ifa ();
  quant_requant_pipe_if #(.LANES(LANES), .CH_AW(CH_AW)) ifb ();

  quant_requant_pipe #(
    .LANES(LANES), .OUT_SIGNED(1'b0),
    .CH_NUM(CHN0), .CH_AW(CH_AW)
  ) u_dut0 (.sclk(sclk), .s_rst_n(s_rst_n), .bus(ifa));

  quant_requant_pipe #(
    .LANES(LANES), .OUT_SIGNED(1'b1),
    .CH_NUM(CHN1), .CH_AW(CH_AW)
  ) u_dut1 (.sclk(sclk), .s_rst_n(s_rst_n), .bus(ifb));

  logic        iv [2];
  logic [5:0]  ich [2];
  logic [127:0] din [2];
  logic        we [2];
  logic [5:0]  wa [2];
  logic [15:0] wm [2];
  logic [4:0]  ws [2];
  logic [7:0]  wz [2];
  logic        clr [2];
  logic        ov [2];
  logic [31:0] dout [2];
  logic [15:0] scnt [2];

  assign ifa.in_valid  = iv[0];
  assign ifa.in_ch     = ich[0];
  assign ifa.data_in   = din[0];
  assign ifa.cfg_we    = we[0];
  assign ifa.cfg_addr  = wa[0];
  assign ifa.cfg_mult  = wm[0];
  assign ifa.cfg_shift = ws[0];
  assign ifa.cfg_zp    = wz[0];
  assign ifa.sat_clr   = clr[0];
  assign ifb.in_valid  = iv[1];
  assign ifb.in_ch     = ich[1];
  assign ifb.data_in   = din[1];
  assign ifb.cfg_we    = we[1];
  assign ifb.cfg_addr  = wa[1];
  assign ifb.cfg_mult  = wm[1];
  assign ifb.cfg_shift = ws[1];
  assign ifb.cfg_zp    = wz[1];
  assign ifb.sat_clr   = clr[1];
  assign ov[0]   = ifa.out_valid;
  assign dout[0] = ifa.data_out;
  assign scnt[0] = ifa.sat_cnt;
  assign ov[1]   = ifb.out_valid;
  assign dout[1] = ifb.data_out;
  assign scnt[1] = ifb.sat_cnt;

  typedef struct {
    int          due;
    int          dut;
    logic [31:0] data;
    int          nsat;
  } exp_t;

  exp_t        eq [$];
  int          cyc = 0;
  int          m_mult [2][64];
  int          m_shift [2][64];
  logic [7:0]  m_zp [2][64];
  int          sat_e [2];
  logic [31:0] last [2];
  logic        clr_e [2];
  int          n_chk = 0;
  int          n_pass = 0;

  task automatic chk(input string tag,
                     input longint got,
                     input longint exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  function automatic int chn(input int d);
    return (d == 0) ? CHN0 : CHN1;
  endfunction

  // real-valued scale with floor((x + half) / 2^s), then zp and clamp
  function automatic void rq(input int d, input int ch,
                             input int acc,
                             output logic [7:0] y,
                             output int sat);
    longint p, num, den, q, v, zp, lo, hi;
    int s;
    y = '0;
    sat = 0;
    if (ch >= chn(d)) return;
    p   = longint'(acc) * longint'(m_mult[d][ch]);
    s   = 15 + m_shift[d][ch];
    den = longint'(1) << s;
    num = p + den / 2;
    q   = num / den;
    if ((num % den != 0) && (num < 0)) q = q - 1;
    if (d == 1) begin
      zp = longint'($signed(m_zp[d][ch]));
      lo = -128;
      hi = 127;
    end else begin
      zp = longint'(m_zp[d][ch]);
      lo = 0;
      hi = 255;
    end
    v = q + zp;
    if (v > hi) begin
      v = hi;
      sat = 1;
    end else if (v < lo) begin
      v = lo;
      sat = 1;
    end
    y = v[7:0];
  endfunction

  task automatic beat(input int d, input int ch,
                      input int a0, input int a1,
                      input int a2, input int a3);
    iv[d]  = 1'b1;
    ich[d] = 6'(ch);
    din[d] = {a3, a2, a1, a0};
  endtask

  task automatic wr(input int d, input int a, input int m,
                    input int s, input int z);
    we[d] = 1'b1;
    wa[d] = 6'(a);
    wm[d] = 16'(m);
    ws[d] = 5'(s);
    wz[d] = 8'(z);
  endtask

  task automatic cycle();
    logic [7:0]  y;
    int          s;
    exp_t        e;
    logic        ev [2];
    logic [31:0] ed [2];
    int          en [2];
    for (int d = 0; d < 2; d++) begin
      if (iv[d]) begin
        e.due  = cyc + 4;
        e.dut  = d;
        e.data = '0;
        e.nsat = 0;
        for (int i = 0; i < LANES; i++) begin
          rq(d, int'(ich[d]), int'(din[d][i*32 +: 32]), y, s);
          e.data[i*8 +: 8] = y;
          e.nsat += s;
        end
        eq.push_back(e);
      end
      if (we[d] && int'(wa[d]) < chn(d)) begin
        m_mult[d][wa[d]]  = int'(wm[d]);
        m_shift[d][wa[d]] = int'(ws[d]);
        m_zp[d][wa[d]]    = wz[d];
      end
      clr_e[d] = clr[d];
      ev[d] = 1'b0;
      ed[d] = '0;
      en[d] = 0;
    end
    @(posedge sclk);
    cyc++;
    #1;
    while (eq.size() > 0 && eq[0].due == cyc) begin
      e = eq.pop_front();
      ev[e.dut] = 1'b1;
      ed[e.dut] = e.data;
      en[e.dut] = e.nsat;
    end
    for (int d = 0; d < 2; d++) begin
      if (clr_e[d]) sat_e[d] = 0;
      else if (ev[d])
        sat_e[d] = (sat_e[d] + en[d] > 65535) ? 65535
                                              : sat_e[d] + en[d];
      if (ev[d]) last[d] = ed[d];
      chk($sformatf("vld%0d@%0d", d, cyc), ov[d], ev[d]);
      chk($sformatf("dat%0d@%0d", d, cyc), dout[d], last[d]);
      chk($sformatf("sat%0d@%0d", d, cyc), scnt[d], sat_e[d]);
      iv[d]  = 1'b0;
      we[d]  = 1'b0;
      clr[d] = 1'b0;
    end
  endtask

  function automatic int ra();
    case ($urandom_range(0, 2))
      0:       return int'($urandom_range(0, 2000)) - 1000;
      1:       return int'($urandom_range(0, 1 << 20)) - (1 << 19);
      default: return int'($urandom);
    endcase
  endfunction

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cycle();
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      iv[d] = 0; ich[d] = '0; din[d] = '0;
      we[d] = 0; wa[d] = '0; wm[d] = '0;
      ws[d] = '0; wz[d] = '0; clr[d] = 0;
      sat_e[d] = 0; last[d] = '0; clr_e[d] = 0;
    end
    #1 s_rst_n = 1'b0;
    repeat (2) @(posedge sclk);
    #1;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("rst_vld%0d", d), ov[d], 0);
      chk($sformatf("rst_dat%0d", d), dout[d], 0);
      chk($sformatf("rst_sat%0d", d), scnt[d], 0);
    end
    s_rst_n = 1'b1;

    for (int ch = 0; ch < 64; ch++) begin
      for (int d = 0; d < 2; d++)
        wr(d, ch, $urandom_range(0, 65535),
           $urandom_range(0, 6), $urandom_range(0, 255));
      cycle();
    end

    // rounding half up on positive and negative halves
    wr(0, 1, 16384, 0, 10);
    cycle();
    beat(0, 1, 5, -5, 0, 3);
    idle(4);
    chk("tp1_l0", dout[0][7:0], 13);
    chk("tp1_l1", dout[0][15:8], 8);
    chk("tp1_l3", dout[0][31:24], 12);

    // unsigned clamp at zero
    wr(0, 2, 32768, 2, 0);
    clr[0] = 1'b1;
    cycle();
    beat(0, 2, 6, -6, 6, 6);
    idle(4);
    chk("tp2_l0", dout[0][7:0], 2);
    chk("tp2_l1", dout[0][15:8], 0);
    chk("tp2_sat", scnt[0], 1);

    // signed clamps, then clear racing a saturating result
    wr(1, 0, 32767, 0, 0);
    clr[1] = 1'b1;
    cycle();
    beat(1, 0, 1000000, -1000, 0, 0);
    idle(4);
    chk("tp3_l0", dout[1][7:0], 8'h7F);
    chk("tp3_l1", dout[1][15:8], 8'h80);
    chk("tp3_sat", scnt[1], 2);
    beat(1, 0, 1000000, -1000, 0, 0);
    idle(3);
    clr[1] = 1'b1;
    cycle();
    chk("tp3_clr", scnt[1], 0);

    // back-to-back, alternating channels 3/7
    wr(0, 3, 20000, 1, 5);
    wr(1, 3, 30000, 0, 8'hFD);
    cycle();
    wr(0, 7, 40000, 3, 200);
    wr(1, 7, 50000, 2, 40);
    cycle();
    for (int k = 0; k < 20; k++) begin
      for (int d = 0; d < 2; d++)
        beat(d, (k % 2) ? 7 : 3, ra(), ra(), ra(), ra());
      cycle();
    end
    idle(4);

    // same-cycle write gives old coefficients, next beat the new ones
    wr(0, 5, 32768, 0, 0);
    cycle();
    wr(0, 5, 32768, 0, 100);
    beat(0, 5, 7, 7, 7, 7);
    cycle();
    beat(0, 5, 7, 7, 7, 7);
    idle(3);
    chk("tp5_old", dout[0][7:0], 7);
    cycle();
    chk("tp5_new", dout[0][7:0], 107);
    wr(0, 50, 1, 0, 77);
    cycle();
    beat(0, 50, 900, 900, 900, 900);
    cycle();
    beat(0, 2, 6, -6, 6, 6);
    idle(5);

    // reset with three beats in flight
    for (int k = 0; k < 3; k++) begin
      for (int d = 0; d < 2; d++)
        beat(d, 3, ra(), ra(), ra(), ra());
      cycle();
    end
    #2 s_rst_n = 1'b0;
    #1;
    eq.delete();
    for (int d = 0; d < 2; d++) begin
      sat_e[d] = 0;
      last[d] = '0;
      chk($sformatf("mid_rst_vld%0d", d), ov[d], 0);
      chk($sformatf("mid_rst_dat%0d", d), dout[d], 0);
      chk($sformatf("mid_rst_sat%0d", d), scnt[d], 0);
    end
    idle(2);
    s_rst_n = 1'b1;
    idle(6);
    for (int d = 0; d < 2; d++)
      beat(d, 7, ra(), ra(), ra(), ra());
    idle(5);

    // randomized traffic, config writes and clears
    for (int k = 0; k < 400; k++) begin
      for (int d = 0; d < 2; d++) begin
        if ($urandom_range(0, 3) != 0)
          beat(d, (d == 0 && $urandom_range(0, 7) == 0)
                    ? int'($urandom_range(48, 63))
                    : int'($urandom_range(0, chn(d) - 1)),
               ra(), ra(), ra(), ra());
        if ($urandom_range(0, 7) == 0)
          wr(d, $urandom_range(0, 63), $urandom_range(0, 65535),
             ($urandom_range(0, 3) == 0) ? $urandom_range(0, 31)
                                         : $urandom_range(0, 8),
             $urandom_range(0, 255));
        if ($urandom_range(0, 31) == 0) clr[d] = 1'b1;
      end
      cycle();
    end
    idle(5);

    // drive sat_cnt into its ceiling
    wr(0, 10, 65535, 0, 255);
    clr[0] = 1'b1;
    cycle();
    for (int k = 0; k < 16400; k++) begin
      beat(0, 10, 32'h7fffffff, 32'h7fffffff,
           32'h7fffffff, 32'h7fffffff);
      cycle();
    end
    idle(4);
    chk("sat_stick", scnt[0], 16'hFFFF);
    clr[0] = 1'b1;
    cycle();
    chk("sat_clr", scnt[0], 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
